// File: rtl/toggle_port_bridge_if.sv
// rtl/toggle_port_bridge_if.sv - toggle-handshake master port plus held-strobe memory controller port
interface toggle_port_bridge_if #(
  parameter int addrwidth = 16,
  parameter int datawidth = 16
);
  logic [addrwidth:1]   port_a;
  logic [datawidth-1:0] port_q;
  logic                 port_we;
  logic                 port_rd_req;
  logic                 port_rd_ack;
  logic                 port_wr_req;
  logic                 port_wr_ack;
  logic [datawidth-1:0] port_d;

  logic [addrwidth:1]   mem_addr;
  logic [datawidth-1:0] mem_wdata;
  logic                 mem_wr;
  logic                 mem_req;
  logic                 mem_ack;
  logic [datawidth-1:0] mem_rdata;

  // master: test master and memory controller side; slave: the bridge
  modport master (
    output port_a, port_q, port_we, port_rd_req, port_wr_req, mem_ack, mem_rdata,
    input  port_rd_ack, port_wr_ack, port_d, mem_addr, mem_wdata, mem_wr, mem_req
  );
  modport slave (
    input  port_a, port_q, port_we, port_rd_req, port_wr_req, mem_ack, mem_rdata,
    output port_rd_ack, port_wr_ack, port_d, mem_addr, mem_wdata, mem_wr, mem_req
  );
endinterface

// File: rtl/toggle_port_bridge.sv
// rtl/toggle_port_bridge.sv - toggle request port to held-strobe memory controller bridge with watchdog
module toggle_port_bridge #(
  parameter int addrwidth = 16,
  parameter int datawidth = 16,
  parameter int timeout   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  toggle_port_bridge_if.slave  bus,
  output logic                 timeout_err,
  output logic [15:0]          timeout_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [15:0] WD_LAST   = 16'(timeout - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_t               state, state_nxt;
  logic [15:0]          watchdog;
  logic                 rd_ack, wr_ack;
  logic [datawidth-1:0] rd_data;
  logic [addrwidth:1]   addr;
  logic [datawidth-1:0] wdata;
  logic                 wr, req;
  logic                 rd_pend, wr_pend, expired;

  assign bus.port_rd_ack = rd_ack;
  assign bus.port_wr_ack = wr_ack;
  assign bus.port_d      = rd_data;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = wdata;
  assign bus.mem_wr      = wr;
  assign bus.mem_req     = req;

  always_comb begin
    rd_pend   = bus.port_rd_req ^ rd_ack;
    wr_pend   = bus.port_wr_req ^ wr_ack;
    // watchdog counts completed ISSUE cycles, so this is the timeout-th cycle of mem_req
    expired   = (watchdog == WD_LAST);
    state_nxt = state;
    case (state)
      IDLE:    if (wr_pend || rd_pend) state_nxt = ISSUE;
      ISSUE:   if (bus.mem_ack || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack        <= 1'b0;
      wr_ack        <= 1'b0;
      rd_data       <= '0;
      addr          <= '0;
      wdata         <= '0;
      wr            <= 1'b0;
      req           <= 1'b0;
      watchdog      <= '0;
      timeout_err   <= 1'b0;
      timeout_count <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_pend) begin
            addr     <= bus.port_a;
            wdata    <= bus.port_q;
            wr       <= 1'b1;
            req      <= 1'b1;
            watchdog <= '0;
          end else if (rd_pend) begin
            addr     <= bus.port_a;
            wr       <= 1'b0;
            req      <= 1'b1;
            watchdog <= '0;
          end
        end
        ISSUE: begin
          // a late mem_ack coinciding with expiry still completes normally
          if (bus.mem_ack) begin
            req <= 1'b0;
            if (!wr) rd_data <= bus.mem_rdata;
          end else if (expired) begin
            req         <= 1'b0;
            timeout_err <= 1'b1;
            if (!wr) rd_data <= '1;
            if (timeout_count != COUNT_MAX) timeout_count <= timeout_count + 16'd1;
          end else begin
            watchdog <= watchdog + 16'd1;
          end
        end
        DONE: begin
          if (wr) wr_ack <= ~wr_ack;
          else    rd_ack <= ~rd_ack;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_port_bridge.sv
// tb/tb_toggle_port_bridge.sv - directed and random scoreboard bench for toggle_port_bridge
module tb_toggle_port_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        terr, terr2;
  logic [15:0] tcnt, tcnt2;

  toggle_port_bridge_if #(.addrwidth(16), .datawidth(16)) bus ();
  toggle_port_bridge_if #(.addrwidth(16), .datawidth(16)) bus2 ();

  toggle_port_bridge #(.addrwidth(16), .datawidth(16), .timeout(255)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .timeout_err(terr), .timeout_count(tcnt)
  );
  toggle_port_bridge #(.addrwidth(16), .datawidth(16), .timeout(8)) dut_to (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .timeout_err(terr2), .timeout_count(tcnt2)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] shadow [16];

  bit          resp_en = 1'b1;
  bit          lat_rand = 1'b0;
  int          lat_fixed = 0;
  bit          rd_ovr_en = 1'b0;
  logic [15:0] rd_ovr = '0;

  int          req_at, ack_at, done_at;
  bit          terr_seen, req_wr, txn_ok;
  logic [15:0] req_addr, req_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // memory controller model: ack after a programmable number of cycles
  initial begin
    int l;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && resp_en) begin
        l = lat_rand ? int'($urandom_range(0, 20)) : lat_fixed;
        repeat (l) @(negedge clk);
        if (bus.mem_wr) mem_model[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = rd_ovr_en ? rd_ovr :
                             (mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 16'h0);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'hDEAD;
      end
    end
  end

  task automatic txn(input bit is_wr, input logic [15:0] a, input logic [15:0] q_or_exp, input int budget);
    int k;
    @(negedge clk);
    bus.port_a  = a;
    bus.port_q  = is_wr ? q_or_exp : 16'h0;
    bus.port_we = is_wr;
    if (is_wr) bus.port_wr_req = ~bus.port_wr_req;
    else begin
      bus.port_rd_req = ~bus.port_rd_req;
      exp_q.push_back(q_or_exp);
    end
    req_at = -1; ack_at = -1; done_at = -1; terr_seen = 0; txn_ok = 0; k = 0;
    while (!txn_ok && k < budget) begin
      @(posedge clk); #1;
      k++;
      if (bus.mem_req && req_at < 0) begin
        req_at = k; req_wr = bus.mem_wr; req_addr = bus.mem_addr; req_wdata = bus.mem_wdata;
      end
      if (bus.mem_ack && ack_at < 0) ack_at = k;
      if (terr) terr_seen = 1;
      if (is_wr ? (bus.port_wr_ack == bus.port_wr_req) : (bus.port_rd_ack == bus.port_rd_req)) begin
        txn_ok = 1; done_at = k;
      end
    end
    chk(is_wr ? "wr_done" : "rd_done", 32'(txn_ok), 32'd1);
    if (!is_wr) chk("rd_data", 32'(bus.port_d), 32'(exp_q.pop_front()));
  endtask

  initial begin
    bit          first_wr, second_wr, wr_before;
    int          nreq, wr_tog, rd_tog, req_cyc, terr_pulses, k2, done2;
    logic        req_prev, wra_prev, rda_prev;
    logic [15:0] v;
    int          idx;

    bus.port_a = '0; bus.port_q = '0; bus.port_we = 0; bus.port_rd_req = 0; bus.port_wr_req = 0;
    bus2.port_a = '0; bus2.port_q = '0; bus2.port_we = 0; bus2.port_rd_req = 0; bus2.port_wr_req = 0;
    bus2.mem_ack = 0; bus2.mem_rdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_wr_ack", 32'(bus.port_wr_ack), 0);
    chk("rst_rd_ack", 32'(bus.port_rd_ack), 0);
    chk("rst_port_d", 32'(bus.port_d), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_terr", 32'(terr), 0);
    chk("rst_tcnt", 32'(tcnt), 0);
    reset_n = 1'b1;

    // write with two extra cycles of controller latency
    lat_fixed = 2;
    txn(1, 16'h0010, 16'hA5A5, 50);
    chk("t1_req_at", 32'(req_at), 1);
    chk("t1_mem_addr", 32'(req_addr), 32'h0010);
    chk("t1_mem_wdata", 32'(req_wdata), 32'hA5A5);
    chk("t1_mem_wr", 32'(req_wr), 1);
    chk("t1_ack_at", 32'(ack_at), 4);
    chk("t1_ack_to_toggle", 32'(done_at - ack_at), 1);
    chk("t1_wr_ack", 32'(bus.port_wr_ack), 1);
    chk("t1_no_terr", 32'(terr_seen), 0);

    // read, ack in first mem_req cycle, forced read data
    lat_fixed = 0; rd_ovr_en = 1; rd_ovr = 16'h1234;
    txn(0, 16'h0010, 16'h1234, 50);
    chk("t2_mem_wr", 32'(req_wr), 0);
    chk("t2_round_trip", 32'(done_at), 3);
    @(posedge clk); #1;
    chk("t2_port_d_held", 32'(bus.port_d), 32'h1234);
    rd_ovr_en = 0;

    // simultaneous write and read toggles
    lat_fixed = 1;
    @(negedge clk);
    req_prev = bus.mem_req; wra_prev = bus.port_wr_ack; rda_prev = bus.port_rd_ack;
    nreq = 0; wr_tog = 0; rd_tog = 0; first_wr = 0; second_wr = 1; wr_before = 0;
    bus.port_a = 16'h0020; bus.port_q = 16'hBEEF; bus.port_we = 1;
    bus.port_wr_req = ~bus.port_wr_req;
    bus.port_rd_req = ~bus.port_rd_req;
    exp_q.push_back(16'hBEEF);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.mem_req && !req_prev) begin
        nreq++;
        if (nreq == 1) first_wr = bus.mem_wr;
        if (nreq == 2) begin
          second_wr = bus.mem_wr;
          wr_before = (bus.port_wr_ack == bus.port_wr_req);
        end
      end
      if (bus.port_wr_ack != wra_prev) wr_tog++;
      if (bus.port_rd_ack != rda_prev) rd_tog++;
      req_prev = bus.mem_req; wra_prev = bus.port_wr_ack; rda_prev = bus.port_rd_ack;
    end
    chk("t3_req_count", 32'(nreq), 2);
    chk("t3_first_is_wr", 32'(first_wr), 1);
    chk("t3_second_is_rd", 32'(second_wr), 0);
    chk("t3_wr_acked_first", 32'(wr_before), 1);
    chk("t3_wr_toggles", 32'(wr_tog), 1);
    chk("t3_rd_toggles", 32'(rd_tog), 1);
    chk("t3_rd_data", 32'(bus.port_d), 32'(exp_q.pop_front()));

    // hung read on the timeout=8 instance
    @(negedge clk);
    bus2.port_a = 16'h0005;
    bus2.port_rd_req = ~bus2.port_rd_req;
    req_cyc = 0; terr_pulses = 0; done2 = -1;
    for (k2 = 1; k2 <= 30; k2++) begin
      @(posedge clk); #1;
      if (bus2.mem_req) req_cyc++;
      if (terr2) terr_pulses++;
      if (done2 < 0 && bus2.port_rd_ack == bus2.port_rd_req) done2 = k2;
    end
    chk("t4_req_cycles", 32'(req_cyc), 8);
    chk("t4_terr_pulses", 32'(terr_pulses), 1);
    chk("t4_tcnt", 32'(tcnt2), 1);
    chk("t4_port_d", 32'(bus2.port_d), 32'hFFFF);
    chk("t4_ack_at", 32'(done2), 10);

    // reset while a write is stuck in ISSUE
    resp_en = 0;
    @(negedge clk);
    bus.port_a = 16'h0030; bus.port_q = 16'h7777; bus.port_we = 1;
    bus.port_wr_req = ~bus.port_wr_req;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_req_before", 32'(bus.mem_req), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_req", 32'(bus.mem_req), 0);
    chk("t5_rst_wr_ack", 32'(bus.port_wr_ack), 0);
    chk("t5_rst_rd_ack", 32'(bus.port_rd_ack), 0);
    chk("t5_rst_tcnt", 32'(tcnt2), 0);
    bus.port_wr_req = 0; bus.port_rd_req = 0;
    bus2.port_wr_req = 0; bus2.port_rd_req = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    resp_en = 1;
    txn(1, 16'h0030, 16'h1111, 50);
    chk("t5_post_terr", 32'(terr_seen), 0);
    txn(0, 16'h0030, 16'h1111, 50);

    // random traffic against the memory model
    lat_rand = 1;
    for (int i = 0; i < 16; i++) begin
      v = 16'($urandom);
      shadow[i] = v;
      txn(1, 16'h0100 + 16'(i), v, 100);
    end
    for (int i = 0; i < 1000; i++) begin
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        v = 16'($urandom);
        shadow[idx] = v;
        txn(1, 16'h0100 + 16'(idx), v, 100);
      end else begin
        txn(0, 16'h0100 + 16'(idx), shadow[idx], 100);
      end
    end
    chk("rand_tcnt", 32'(tcnt), 0);
    chk("rand_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/toggle_port_bridge.md
Name: toggle_port_bridge

Overview:
- Downstream of the port test master. Accepts its toggle-handshake port (rd_req/rd_ack, wr_req/wr_ack, address, write data, we).
- Converts each pending toggle request into a single held-strobe transaction on a memory controller interface (mem_req held until a mem_ack pulse).
- Returns read data and toggles the matching ack.
- Adds a watchdog that completes a hung transaction and flags it, so the test master never deadlocks.

Parameters:
- addrwidth, 16, port address width; address bits are [addrwidth:1] (16-bit word addressing).
- datawidth, 16, data bus width.
- timeout, 255, maximum cycles mem_req may stay high without mem_ack; must be in 1..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- port_a  in  addrwidth (bits addrwidth:1)  request address.
- port_q  in  datawidth  write data from master.
- port_we  in  1  write enable qualifier from master (informational; direction comes from which toggle is pending).
- port_rd_req  in  1  read request toggle.
- port_rd_ack  out  1  read acknowledge toggle.
- port_wr_req  in  1  write request toggle.
- port_wr_ack  out  1  write acknowledge toggle.
- port_d  out  datawidth  read data to master, registered.
- mem_addr  out  addrwidth (bits addrwidth:1)  controller address.
- mem_wdata  out  datawidth  controller write data.
- mem_wr  out  1  1 = write, 0 = read.
- mem_req  out  1  request strobe, held until mem_ack.
- mem_ack  in  1  single-cycle completion pulse.
- mem_rdata  in  datawidth  read data, valid in the mem_ack cycle.
- timeout_err  out  1  one-cycle pulse when a transaction times out.
- timeout_count  out  16  saturating count of timeouts.

Behaviour:
- Reset values (asynchronous):
  - port_rd_ack=0, port_wr_ack=0.
  - port_d=0, mem_addr=0, mem_wdata=0, mem_wr=0, mem_req=0.
  - timeout_err=0, timeout_count=0.
  - state=IDLE, watchdog=0.
- Pending conditions: rd_pend = port_rd_req XOR port_rd_ack; wr_pend = port_wr_req XOR port_wr_ack. Evaluated on registered ack state.
- IDLE:
  - If wr_pend: latch port_a into mem_addr and port_q into mem_wdata; mem_wr=1, mem_req=1, watchdog=0, go to ISSUE.
  - Else if rd_pend: latch port_a into mem_addr; mem_wr=0, mem_req=1, watchdog=0, go to ISSUE.
  - Write has fixed priority when both are pending in the same cycle; the read is served on the next IDLE pass.
- ISSUE:
  - mem_req stays high; mem_addr, mem_wdata and mem_wr are held stable.
  - watchdog increments each cycle.
  - On mem_ack=1:
    - mem_req=0.
    - If read, port_d<=mem_rdata.
    - Go to DONE.
  - Else if watchdog reaches timeout:
    - mem_req=0.
    - If read, port_d<={datawidth{1'b1}}.
    - timeout_err pulses for 1 cycle; timeout_count increments, saturating at 16'hFFFF.
    - Go to DONE.
- DONE:
  - Toggle port_wr_ack (write) or port_rd_ack (read), go to IDLE.
  - port_d is already stable in this cycle and is held until the next read completes, so a master sampling data one cycle after the ack is safe.
- Latency:
  - Request toggle sampled in IDLE → mem_req high the next cycle.
  - mem_ack at cycle N → ack toggles at N+1, visible at N+2.
  - Minimum toggle-to-ack round trip: 3 cycles with mem_ack returned in the first mem_req cycle.
- Exactly one transaction is outstanding at a time. Toggles arriving while busy stay pending and are serviced in order of the priority rule.
- mem_ack while not in ISSUE is ignored.
- mem_ack arriving in the same cycle the watchdog expires: mem_ack wins, no timeout.
- Reset mid-transaction: everything returns to reset values immediately, including ack toggles. The master must also be reset; any in-flight controller request is abandoned.
- Data bits are passed without transformation; address width is passed through unchanged.

Test Plan:
- Write a=16'h0010 q=16'hA5A5, mem_ack 2 cycles after mem_req → mem_addr=16'h0010, mem_wdata=16'hA5A5, mem_wr=1; port_wr_ack toggles 0→1 one cycle after mem_ack; no timeout_err.
- Read a=16'h0010, mem_ack with mem_rdata=16'h1234 in the first mem_req cycle → port_d=16'h1234 when port_rd_ack toggles; round trip 3 cycles.
- Toggle port_wr_req and port_rd_req in the same cycle → write issued first (mem_wr=1); read issued only after port_wr_ack toggles; both acks toggled exactly once.
- Read with mem_ack never asserted, timeout=8 → mem_req drops after 8 cycles; timeout_err pulses once; timeout_count=1; port_d=16'hFFFF; port_rd_ack toggles.
- Assert reset_n=0 while in ISSUE → mem_req=0, acks=0, timeout_count=0 immediately. After release, a new write completes normally.
- 1000 back-to-back random read/write toggles against a bench memory model with random 0–20 cycle ack latency → every read returns the last written value; timeout_count=0.
